sd_port_arbiter: RTL and testbench
==================================

Name: sd_port_arbiter

Overview:
- Shares the single SD-card controller port between two requesters: port 0, the histogram writer (slot save), and port 1, the histogram reader (slot load).
- Grants are session-based. A requester holds the SD port across a whole multi-sector transfer (4 × 512-byte sectors per slot) for as long as it holds req.
- Sits between the requester blocks and the SD controller. It multiplexes address, rd, wr and din toward the controller, and routes ready, dout and the byte strobes back to the owner only.
- Includes an inactivity watchdog that revokes a grant from a stuck owner.

Parameters:
- IDLE_TIMEOUT, default 24'd10_000_000: cycles with the owner holding the grant, sd_ready high and no rd/wr asserted before the grant is revoked.
- TO_W, default 24: width of the watchdog counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req  in  2  per-port session request; bit 0 is writer, bit 1 is reader
- p0_address  in  32  port 0 SD byte address
- p0_wr  in  1  port 0 write start
- p0_din  in  8  port 0 write byte
- p1_address  in  32  port 1 SD byte address
- p1_rd  in  1  port 1 read start
- gnt  out  2  one-hot registered grant
- p_ready  out  2  per-port gated sd_ready
- p_ready_for_next_byte  out  2  per-port gated write strobe
- p_byte_available  out  2  per-port gated read strobe
- p_dout  out  8  read data, valid to owner only
- timeout_err  out  1  one-cycle pulse when a grant is revoked
- sd_ready  in  1  controller idle
- sd_dout  in  8  controller read byte
- sd_byte_available  in  1  controller read strobe
- sd_ready_for_next_byte  in  1  controller write strobe
- sd_address  out  32  to controller
- sd_rd  out  1  to controller
- sd_wr  out  1  to controller
- sd_din  out  8  to controller

Behaviour:
- Reset values:
  - state IDLE, gnt=2'b00, timeout_err=0, watchdog=0.
  - last_owner=1, so port 0 wins the first tie.
  - Because state is IDLE, sd_rd=sd_wr=0, sd_address=0, sd_din=0 and all p_* outputs are 0.
- State IDLE: SD outputs are driven 0.
  - If sd_ready=1 and req≠0, pick the winner: a single requester wins; on tie, the port ≠ last_owner wins.
  - Next cycle: gnt is set one-hot, last_owner is set to the winner, watchdog is cleared, state goes to OWN.
  - If sd_ready=0, stay in IDLE; no grant is issued.
- State OWN: sd_address, sd_rd, sd_wr and sd_din are combinationally muxed from the owner; zero added latency.
  - Port 0 never drives sd_rd; port 1 never drives sd_wr. The unused strobe is tied 0.
  - The owner's p_ready, p_ready_for_next_byte and p_byte_available follow the controller signals. The non-owner's copies are 0.
  - p_dout = sd_dout while in OWN, else 0.
- Release:
  - Owner drops req with sd_ready=1: go to IDLE, gnt clears next cycle.
  - Owner drops req with sd_ready=0 (transfer mid-sector): go to DRAIN.
- State DRAIN: sd_rd=sd_wr=0 and gnt is held. Wait for sd_ready=1, then go to IDLE. A sector in progress is never aborted.
- Watchdog (OWN only):
  - Increments while sd_ready=1 and owner rd/wr=0.
  - Clears on any rd/wr or on sd_ready=0.
  - On reaching IDLE_TIMEOUT-1: timeout_err pulses for 1 cycle and state goes to IDLE.
  - The revoked port is masked from arbitration until its req deasserts (penalty bit per port, cleared on req=0 or reset).
- Grant fairness: back-to-back requests alternate. No port gets two consecutive grants while the other is waiting.
- Minimum gap between sessions: 1 IDLE cycle.
- A req rising while another port owns the bus waits. It is not queued beyond req itself; the requester must hold req.
- Reset mid-session: immediate return to IDLE with gnt=0 and the SD strobes dropped. The controller is responsible for its own recovery.
- A req glitch (1-cycle) in IDLE with sd_ready=1 still produces a grant, which releases on the following cycle.

Decomposition:
- Shared package sd_pkg: state encodings (IDLE, OWN, DRAIN), port indices (PORT_WR=0, PORT_RD=1), sector size 512, sectors per slot 4.
- One sub-module, sd_rr_pick2: a combinational 2-way round-robin picker taking req, mask and last_owner and returning a one-hot winner.
- Muxing and the watchdog stay in the top level.

Test Plan:
- Single writer: req=01, sd_ready=1 → gnt=01 next cycle; p0_wr=1 with p0_address=0x1000 appears on sd_wr/sd_address the same cycle; p_ready[1]=0 throughout.
- Tie: req=11 after reset → gnt=01. Port 0 releases, port 1 holds → gnt=00 for 1 cycle, then gnt=10. Port 0 re-requests → granted only after port 1 drops req.
- Mid-sector drop: owner port 1 drops req with sd_ready=0 → state DRAIN, sd_rd=0, gnt=10 held until sd_ready=1, then gnt=00.
- Watchdog (IDLE_TIMEOUT=16): port 0 granted, sd_ready=1, no wr for 16 cycles → timeout_err pulse, gnt=00. Port 0 is ignored until its req drops; port 1 is granted if requesting.
- Isolation: port 1 owns, sd_byte_available toggles with sd_dout=0xA5 → p_byte_available=10, p_dout=0xA5; p_byte_available[0] stays 0.
- Reset asserted while in OWN with sd_wr=1 → next cycle gnt=0, sd_wr=0, timeout_err=0.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the SD-port arbiter: FSM states, port indices and
// transfer geometry.
package sd_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } sd_state_e;

  localparam int PORT_WR          = 0;
  localparam int PORT_RD          = 1;
  localparam int SECTOR_BYTES     = 512;
  localparam int SECTORS_PER_SLOT = 4;
  localparam int SLOT_BYTES       = SECTOR_BYTES * SECTORS_PER_SLOT;
endpackage

// File: rtl/sd_rr_pick2.sv
// Two-way round-robin picker: masked requests in, one-hot winner out.
module sd_rr_pick2
  import sd_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  input  logic       i_last,
  output logic [1:0] o_win
);
  logic [1:0] w_elig;

  always_comb begin
    w_elig = i_req & ~i_mask;
    o_win  = 2'b00;
    case (w_elig)
      2'b01: o_win = 2'b01;
      2'b10: o_win = 2'b10;
      2'b11: begin
        // On a tie the port that did not own the bus last time wins.
        o_win[PORT_RD] = (i_last == 1'(PORT_WR));
        o_win[PORT_WR] = ~o_win[PORT_RD];
      end
      default: o_win = 2'b00;
    endcase
  end
endmodule

// File: rtl/sd_port_arbiter.sv
// Session-based arbiter sharing one SD controller between the histogram
// writer (port 0) and reader (port 1), with an inactivity watchdog.
module sd_port_arbiter
  import sd_pkg::*;
#(
  parameter int              TO_W         = 24,
  parameter logic [TO_W-1:0] IDLE_TIMEOUT = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [31:0] p0_address,
  input  logic        p0_wr,
  input  logic [7:0]  p0_din,
  input  logic [31:0] p1_address,
  input  logic        p1_rd,
  output logic [1:0]  gnt,
  output logic [1:0]  p_ready,
  output logic [1:0]  p_ready_for_next_byte,
  output logic [1:0]  p_byte_available,
  output logic [7:0]  p_dout,
  output logic        timeout_err,
  input  logic        sd_ready,
  input  logic [7:0]  sd_dout,
  input  logic        sd_byte_available,
  input  logic        sd_ready_for_next_byte,
  output logic [31:0] sd_address,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [7:0]  sd_din
);
  localparam logic [TO_W-1:0] WD_LAST = IDLE_TIMEOUT - 1'b1;

  sd_state_e       r_state, w_state_nxt;
  logic [1:0]      r_gnt, w_gnt_nxt;
  logic            r_last, w_last_nxt;
  logic [TO_W-1:0] r_wd, w_wd_nxt;
  logic [1:0]      r_pen, w_pen_nxt;
  logic            r_to_err, w_to_err_nxt;
  logic [1:0]      w_pick;
  logic            w_own, w_own_req, w_own_act, w_in_own, w_has_bus;

  sd_rr_pick2 u_pick (
    .i_req  (req),
    .i_mask (r_pen),
    .i_last (r_last),
    .o_win  (w_pick)
  );

  assign w_own     = r_gnt[PORT_RD];
  assign w_own_req = req[w_own];
  assign w_own_act = w_own ? p1_rd : p0_wr;
  assign w_in_own  = (r_state == ST_OWN);
  assign w_has_bus = (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_last_nxt   = r_last;
    w_wd_nxt     = r_wd;
    w_pen_nxt    = r_pen & req;
    w_to_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sd_ready && (w_pick != 2'b00)) begin
          w_state_nxt = ST_OWN;
          w_gnt_nxt   = w_pick;
          w_last_nxt  = w_pick[PORT_RD];
          w_wd_nxt    = '0;
        end
      end
      ST_OWN: begin
        if (!w_own_req) begin
          // A sector in flight must finish before the bus is handed over.
          w_state_nxt = sd_ready ? ST_IDLE : ST_DRAIN;
          w_gnt_nxt   = sd_ready ? 2'b00 : r_gnt;
        end else if (sd_ready && !w_own_act) begin
          if (r_wd == WD_LAST) begin
            w_state_nxt      = ST_IDLE;
            w_gnt_nxt        = 2'b00;
            w_to_err_nxt     = 1'b1;
            w_pen_nxt[w_own] = 1'b1;
          end else begin
            w_wd_nxt = r_wd + 1'b1;
          end
        end else begin
          w_wd_nxt = '0;
        end
      end
      ST_DRAIN: begin
        if (sd_ready) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = 2'b00;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 2'b00;
      r_last   <= 1'b1;
      r_wd     <= '0;
      r_pen    <= 2'b00;
      r_to_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_last   <= w_last_nxt;
      r_wd     <= w_wd_nxt;
      r_pen    <= w_pen_nxt;
      r_to_err <= w_to_err_nxt;
    end
  end

  // Address and data stay on the owner through DRAIN; only the start strobes drop.
  assign sd_address = !w_has_bus ? 32'd0 : (w_own ? p1_address : p0_address);
  assign sd_din     = (w_has_bus && !w_own) ? p0_din : 8'd0;
  assign sd_wr      = w_in_own && !w_own && p0_wr;
  assign sd_rd      = w_in_own &&  w_own && p1_rd;

  assign p_ready               = w_in_own ? (r_gnt & {2{sd_ready}})               : 2'b00;
  assign p_ready_for_next_byte = w_in_own ? (r_gnt & {2{sd_ready_for_next_byte}}) : 2'b00;
  assign p_byte_available      = w_in_own ? (r_gnt & {2{sd_byte_available}})      : 2'b00;
  assign p_dout                = w_in_own ? sd_dout : 8'd0;

  assign gnt         = r_gnt;
  assign timeout_err = r_to_err;
endmodule

// File: tb/tb_sd_port_arbiter.sv
// Self-checking bench for sd_port_arbiter: directed vector table, hand-written
// watchdog/reset sequences and a randomized run against a session-level model.
module tb_sd_port_arbiter;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] p0_address, p1_address, sd_address;
  logic        p0_wr, p1_rd, sd_rd, sd_wr;
  logic [7:0]  p0_din, p_dout, sd_dout, sd_din;
  logic [1:0]  gnt, p_ready, p_ready_for_next_byte, p_byte_available;
  logic        timeout_err, sd_ready, sd_byte_available, sd_ready_for_next_byte;

  int n_cmp = 0;
  int n_bad = 0;

  sd_port_arbiter #(.TO_W(24), .IDLE_TIMEOUT(24'd16)) dut (
    .clk(clk), .reset(reset), .req(req),
    .p0_address(p0_address), .p0_wr(p0_wr), .p0_din(p0_din),
    .p1_address(p1_address), .p1_rd(p1_rd),
    .gnt(gnt), .p_ready(p_ready), .p_ready_for_next_byte(p_ready_for_next_byte),
    .p_byte_available(p_byte_available), .p_dout(p_dout), .timeout_err(timeout_err),
    .sd_ready(sd_ready), .sd_dout(sd_dout), .sd_byte_available(sd_byte_available),
    .sd_ready_for_next_byte(sd_ready_for_next_byte),
    .sd_address(sd_address), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_din(sd_din)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic        rdy, wr, rd, ba;
    logic [7:0]  dout;
    logic [1:0]  gnt;
    logic        swr, srd;
    logic [31:0] addr;
    logic [1:0]  prdy, pba;
    logic [7:0]  pdout;
    logic        err;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic rst, logic [1:0] rq, logic rdy, logic wr, logic rd,
                              logic ba, logic [7:0] dout, logic [1:0] g, logic swr,
                              logic srd, logic [31:0] addr, logic [1:0] prdy,
                              logic [1:0] pba, logic [7:0] pdout, logic err);
    vec_t v;
    v.rst = rst; v.req = rq; v.rdy = rdy; v.wr = wr; v.rd = rd; v.ba = ba; v.dout = dout;
    v.gnt = g; v.swr = swr; v.srd = srd; v.addr = addr; v.prdy = prdy; v.pba = pba;
    v.pdout = pdout; v.err = err;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(logic rst, logic [1:0] rq, logic rdy, logic wr, logic rd,
                     logic ba, logic [7:0] dout);
    reset = rst; req = rq; sd_ready = rdy; p0_wr = wr; p1_rd = rd;
    sd_byte_available = ba; sd_dout = dout;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Session-level reference: who holds the bus, whether it is draining,
  // how long it has been quiet, and which ports are serving a penalty.
  int       m_owner;
  bit       m_drain;
  int       m_quiet;
  bit [1:0] m_pen;
  int       m_last;
  bit       m_err;

  task automatic model_reset();
    m_owner = -1; m_drain = 0; m_quiet = 0; m_pen = 2'b00; m_last = 1; m_err = 0;
  endtask

  task automatic model_edge();
    bit [1:0] np;
    bit       ne;
    int       cands;
    if (reset) begin
      model_reset();
      return;
    end
    np = m_pen & req;
    ne = 0;
    if (m_owner < 0) begin
      cands = 0;
      for (int p = 0; p < 2; p++) if (req[p] && !m_pen[p]) cands++;
      if (sd_ready && cands > 0) begin
        if (cands == 2) m_owner = 1 - m_last;
        else m_owner = (req[0] && !m_pen[0]) ? 0 : 1;
        m_last  = m_owner;
        m_quiet = 0;
      end
    end else if (m_drain) begin
      if (sd_ready) begin m_owner = -1; m_drain = 0; end
    end else if (!req[m_owner]) begin
      if (sd_ready) m_owner = -1;
      else m_drain = 1;
    end else if (sd_ready && !(m_owner == 0 ? p0_wr : p1_rd)) begin
      if (m_quiet == TO - 1) begin
        ne = 1;
        np[m_owner] = 1;
        m_owner = -1;
      end else begin
        m_quiet++;
      end
    end else begin
      m_quiet = 0;
    end
    m_pen = np;
    m_err = ne;
  endtask

  initial begin
    logic [1:0]  e_gnt;
    logic [31:0] e_addr;
    logic [7:0]  e_din;
    bit          act;
    bit          quiet_mode;

    tbl[0]  = mk(0, 2'b01, 1, 0, 0, 0, 8'h00, 2'b00, 0, 0, 32'h0,    2'b00, 2'b00, 8'h00, 0);
    tbl[1]  = mk(0, 2'b01, 1, 1, 0, 0, 8'h00, 2'b01, 1, 0, 32'h1000, 2'b01, 2'b00, 8'h00, 0);
    tbl[2]  = mk(0, 2'b01, 0, 0, 0, 0, 8'h00, 2'b01, 0, 0, 32'h1000, 2'b00, 2'b00, 8'h00, 0);
    tbl[3]  = mk(0, 2'b00, 1, 0, 0, 0, 8'h00, 2'b01, 0, 0, 32'h1000, 2'b01, 2'b00, 8'h00, 0);
    tbl[4]  = mk(0, 2'b00, 1, 0, 0, 0, 8'h00, 2'b00, 0, 0, 32'h0,    2'b00, 2'b00, 8'h00, 0);
    tbl[5]  = mk(1, 2'b00, 1, 0, 0, 0, 8'h00, 2'b00, 0, 0, 32'h0,    2'b00, 2'b00, 8'h00, 0);
    tbl[6]  = mk(0, 2'b11, 1, 0, 0, 0, 8'h00, 2'b00, 0, 0, 32'h0,    2'b00, 2'b00, 8'h00, 0);
    tbl[7]  = mk(0, 2'b10, 1, 0, 1, 0, 8'h00, 2'b01, 0, 0, 32'h1000, 2'b01, 2'b00, 8'h00, 0);
    tbl[8]  = mk(0, 2'b10, 1, 0, 0, 0, 8'h00, 2'b00, 0, 0, 32'h0,    2'b00, 2'b00, 8'h00, 0);
    tbl[9]  = mk(0, 2'b11, 1, 0, 1, 0, 8'h00, 2'b10, 0, 1, 32'h2000, 2'b10, 2'b00, 8'h00, 0);
    tbl[10] = mk(0, 2'b11, 1, 0, 0, 1, 8'hA5, 2'b10, 0, 0, 32'h2000, 2'b10, 2'b10, 8'hA5, 0);
    tbl[11] = mk(0, 2'b01, 0, 0, 0, 0, 8'hA5, 2'b10, 0, 0, 32'h2000, 2'b00, 2'b00, 8'hA5, 0);
    tbl[12] = mk(0, 2'b01, 0, 0, 1, 1, 8'hA5, 2'b10, 0, 0, 32'h2000, 2'b00, 2'b00, 8'h00, 0);
    tbl[13] = mk(0, 2'b01, 1, 0, 0, 0, 8'hA5, 2'b10, 0, 0, 32'h2000, 2'b00, 2'b00, 8'h00, 0);
    tbl[14] = mk(0, 2'b01, 1, 0, 0, 0, 8'h00, 2'b00, 0, 0, 32'h0,    2'b00, 2'b00, 8'h00, 0);
    tbl[15] = mk(0, 2'b00, 1, 0, 0, 0, 8'h00, 2'b01, 0, 0, 32'h1000, 2'b01, 2'b00, 8'h00, 0);
    tbl[16] = mk(0, 2'b00, 1, 0, 0, 0, 8'h00, 2'b00, 0, 0, 32'h0,    2'b00, 2'b00, 8'h00, 0);
    tbl[17] = mk(0, 2'b01, 0, 0, 0, 0, 8'h00, 2'b00, 0, 0, 32'h0,    2'b00, 2'b00, 8'h00, 0);
    tbl[18] = mk(0, 2'b01, 1, 0, 0, 0, 8'h00, 2'b00, 0, 0, 32'h0,    2'b00, 2'b00, 8'h00, 0);

    p0_address = 32'h1000; p1_address = 32'h2000; p0_din = 8'h3C;
    sd_ready_for_next_byte = 1'b0;
    drv(1, 2'b00, 1, 0, 0, 1, 8'hFF);
    next_cycle();
    next_cycle();
    #2;
    chk("reset_gnt_err", 64'({gnt, timeout_err}), 64'(3'b000));
    chk("reset_sd_side", 64'({sd_rd, sd_wr, sd_address, sd_din}), 64'(0));
    chk("reset_p_side", 64'({p_ready, p_ready_for_next_byte, p_byte_available, p_dout}), 64'(0));
    next_cycle();

    for (int i = 0; i < 19; i++) begin
      drv(tbl[i].rst, tbl[i].req, tbl[i].rdy, tbl[i].wr, tbl[i].rd, tbl[i].ba, tbl[i].dout);
      #2;
      chk($sformatf("vec%0d", i),
          64'({gnt, sd_wr, sd_rd, sd_address, p_ready, p_byte_available, p_dout, timeout_err}),
          64'({tbl[i].gnt, tbl[i].swr, tbl[i].srd, tbl[i].addr, tbl[i].prdy, tbl[i].pba,
               tbl[i].pdout, tbl[i].err}));
      next_cycle();
    end

    // Port 0 owns and sits quiet with sd_ready high; port 1 waits.
    for (int k = 0; k < TO; k++) begin
      drv(0, 2'b11, 1, 0, 0, 0, 8'h00);
      #2;
      chk($sformatf("wd_hold%0d", k), 64'({gnt, timeout_err}), 64'({2'b01, 1'b0}));
      next_cycle();
    end
    drv(0, 2'b11, 1, 0, 0, 0, 8'h00); #2;
    chk("wd_revoke", 64'({gnt, timeout_err}), 64'({2'b00, 1'b1})); next_cycle();
    drv(0, 2'b11, 1, 0, 0, 0, 8'h00); #2;
    chk("wd_p1_granted", 64'({gnt, timeout_err}), 64'({2'b10, 1'b0})); next_cycle();
    drv(0, 2'b01, 1, 0, 0, 0, 8'h00); #2;
    chk("wd_p1_release", 64'(gnt), 64'(2'b10)); next_cycle();
    for (int k = 0; k < 2; k++) begin
      drv(0, 2'b01, 1, 0, 0, 0, 8'h00); #2;
      chk($sformatf("wd_p0_masked%0d", k), 64'(gnt), 64'(2'b00)); next_cycle();
    end
    drv(0, 2'b00, 1, 0, 0, 0, 8'h00); #2;
    chk("wd_p0_drop", 64'(gnt), 64'(2'b00)); next_cycle();
    drv(0, 2'b01, 1, 0, 0, 0, 8'h00); #2;
    chk("wd_p0_rereq", 64'(gnt), 64'(2'b00)); next_cycle();
    drv(0, 2'b01, 1, 1, 0, 0, 8'h00); #2;
    chk("wd_p0_regrant", 64'({gnt, sd_wr, sd_address}), 64'({2'b01, 1'b1, 32'h1000}));
    next_cycle();

    drv(1, 2'b01, 1, 1, 0, 0, 8'h00); #2;
    chk("rst_pre", 64'({gnt, sd_wr, sd_address}), 64'({2'b01, 1'b1, 32'h1000})); next_cycle();
    drv(1, 2'b01, 1, 1, 0, 0, 8'h00); #2;
    chk("rst_post", 64'({gnt, sd_wr, timeout_err}), 64'(0)); next_cycle();

    model_reset();
    for (int c = 0; c < 3000; c++) begin
      quiet_mode = ((c / 400) % 2) == 1;
      reset = ($urandom_range(255) == 0);
      for (int p = 0; p < 2; p++) if ($urandom_range(11) == 0) req[p] = ~req[p];
      sd_ready = quiet_mode ? ($urandom_range(19) != 0) : ($urandom_range(3) != 0);
      p0_wr = quiet_mode ? ($urandom_range(39) == 0) : ($urandom_range(9) == 0);
      p1_rd = quiet_mode ? ($urandom_range(39) == 0) : ($urandom_range(9) == 0);
      p0_address = $urandom; p1_address = $urandom;
      p0_din = 8'($urandom); sd_dout = 8'($urandom);
      sd_byte_available = 1'($urandom); sd_ready_for_next_byte = 1'($urandom);
      #2;
      e_gnt  = (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
      act    = (m_owner >= 0) && !m_drain;
      e_addr = (m_owner < 0) ? 32'h0 : (m_owner == 1 ? p1_address : p0_address);
      e_din  = (m_owner == 0) ? p0_din : 8'h00;
      chk($sformatf("rand%0d", c),
          64'({gnt, sd_rd, sd_wr, sd_address, sd_din, p_ready, p_ready_for_next_byte,
               p_byte_available, p_dout, timeout_err}),
          64'({e_gnt, act && m_owner == 1 && p1_rd, act && m_owner == 0 && p0_wr, e_addr, e_din,
               act ? (e_gnt & {2{sd_ready}}) : 2'b00,
               act ? (e_gnt & {2{sd_ready_for_next_byte}}) : 2'b00,
               act ? (e_gnt & {2{sd_byte_available}}) : 2'b00,
               act ? sd_dout : 8'h00, m_err}));
      model_edge();
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
